slti_operand_stage: RTL and testbench
=====================================

// Module: slti_operand_stage
// PURPOSE
//  Decode/operand stage directly upstream of the SLTI compare function. Accepts one
//  16-bit instruction plus its rs register value per handshake, forwards a pending
//  writeback, extends the immediate and registers {A, B, rt, slti_en} for the comparator.
//  Valid/ready on both sides; a 2-entry skid buffer keeps full throughput under backpressure.
// PARAMETERS
//  DATA_W        16     operand width
//  IMM_W         6      immediate field width (instr[IMM_W-1:0])
//  REG_ADDR_W    3      register address width
//  OPC_SLTI      4'h7   opcode (instr[15:12]) that asserts out_slti_en
//  SIGN_EXT_IMM  1      1: sign-extend immediate, 0: zero-extend
// PORTS
//  clk          in   1           single clock, rising edge
//  reset        in   1           asynchronous, active-high
//  in_valid     in   1           instruction + rs data valid
//  in_ready     out  1           stage can accept this cycle
//  in_instr     in   DATA_W      {opcode[15:12], rs[11:9], rt[8:6], imm[5:0]}
//  in_rs_data   in   DATA_W      register-file read of rs
//  wb_we        in   1           writeback this cycle
//  wb_addr      in   REG_ADDR_W  writeback destination
//  wb_data      in   DATA_W      writeback value
//  out_valid    out  1           output fields valid
//  out_ready    in   1           comparator consumes this cycle
//  out_a        out  DATA_W      operand A (rs value, forwarded)
//  out_b        out  DATA_W      extended immediate
//  out_rt       out  REG_ADDR_W  destination register
//  out_slti_en  out  1           opcode == OPC_SLTI
// BEHAVIOUR
//  - Reset (async, any cycle incl. mid-transfer): both entries invalid, out_valid=0,
//    out_a/out_b/out_rt/out_slti_en=0, in_ready=1 from the cycle after reset deasserts.
//  - Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
//  - Latency: accepted instruction appears on out_* the next cycle (1 cycle) when empty.
//  - Operand A at capture: rs==0 -> 0; else wb_we&&wb_addr==rs -> wb_data; else in_rs_data.
//    Writeback to r0 never forwards.
//  - Operand B: imm sign- or zero-extended per SIGN_EXT_IMM to DATA_W; imm=6'h20 -> 16'hFFE0
//    signed, 16'h0020 unsigned.
//  - Buffer states: EMPTY (0 valid), ONE (main valid), FULL (main+skid valid).
//    EMPTY -in-> ONE; ONE -in&!out-> FULL (new word to skid); ONE -in&out-> ONE (replace);
//    ONE -out&!in-> EMPTY; FULL -out-> ONE (skid moves to main); FULL never accepts.
//  - in_ready = registered (state != FULL); no combinational in_ready<-out_ready path.
//  - Output fields stable while out_valid&!out_ready; order strictly FIFO; no drops/dups.
//  - Forwarding samples wb_* in the accept cycle only; later writebacks do not update
//    already-buffered operands (pipeline control stalls for that hazard).
//  - Simultaneous accept and pop in ONE: pop old, load new, stays ONE, out_valid stays 1.
// STRUCTURE
//  - Shared package (cpu_pkg): DATA_W, REG_ADDR_W, opcode constants (OPC_SLTI etc.),
//    instruction field bit positions, operand bundle struct {a, b, rt, slti_en}.
//  - One sub-module: operand_skid_buffer (2-entry, width-parameterised, valid/ready);
//    extension, r0 handling and forwarding mux stay in the top as combinational logic.
// TESTING
//  - Reset: reset=1 mid-stream -> out_valid=0, all out_*=0 same cycle; in_ready=1 after.
//  - Basic: instr 16'h7245 (rs=1,rt=1,imm=5), rs_data=16'h0003, out_ready=1 -> next cycle
//    out_a=3, out_b=5, out_rt=1, out_slti_en=1.
//  - Extension: imm=6'h3F, SIGN_EXT_IMM=1 -> out_b=16'hFFFF; SIGN_EXT_IMM=0 -> 16'h003F.
//  - Forwarding: rs=2, rs_data=16'h0010, wb_we=1, wb_addr=2, wb_data=16'h1234 -> out_a=16'h1234;
//    rs=0 with wb_addr=0, wb_data=16'hFFFF -> out_a=0.
//  - Backpressure: 3 back-to-back instrs, out_ready=0 -> in_ready=0 after 2nd; release
//    -> all 3 emerge in order, fields held stable while stalled, none lost.
//  - Streaming: in_valid=out_ready=1 for 100 cycles, random stalls -> 1 instr/cycle when
//    unstalled; scoreboard matches a reference model exactly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants, instruction field positions and the operand bundle
// handed from the decode/operand stage to the SLTI comparator.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int IMM_W      = 6;
  localparam int REG_ADDR_W = 3;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 6;

  localparam logic [3:0] OPC_SLTI = 4'h7;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]     a;
    logic [DATA_W-1:0]     b;
    logic [REG_ADDR_W-1:0] rt;
    logic                  slti_en;
  } operand_t;

  // Widen the immediate field to a full operand, replicating its top bit when signed.
  function automatic logic [DATA_W-1:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                   input logic sign_ext);
    if (sign_ext)
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    else
      return {{(DATA_W-IMM_W){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/operand_skid_buffer.sv
// Two-entry valid/ready skid buffer: "main" drives the output, "skid" absorbs the
// word accepted in the cycle the consumer stalls, so in_ready never depends on out_ready.
module operand_skid_buffer
  import cpu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         push;
  logic         pop;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          main_d  = in_data_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          main_d = in_data_i;
        end else if (push) begin
          skid_d  = in_data_i;
          state_d = BUF_FULL;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // Full never accepts, so a pop only promotes the older skid word.
        if (pop) begin
          main_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q != BUF_FULL);
    out_valid_o = (state_q != BUF_EMPTY);
    out_data_o  = main_q;
  end

endmodule

// File: rtl/slti_operand_stage.sv
// Operand stage ahead of the SLTI comparator: forwards a same-cycle writeback into
// operand A, extends the immediate into operand B and buffers the bundle.
module slti_operand_stage #(
  parameter logic [3:0] OPC_SLTI     = cpu_pkg::OPC_SLTI,
  parameter bit         SIGN_EXT_IMM = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [cpu_pkg::DATA_W-1:0]      in_instr,
  input  logic [cpu_pkg::DATA_W-1:0]      in_rs_data,
  input  logic                            wb_we,
  input  logic [cpu_pkg::REG_ADDR_W-1:0]  wb_addr,
  input  logic [cpu_pkg::DATA_W-1:0]      wb_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [cpu_pkg::DATA_W-1:0]      out_a,
  output logic [cpu_pkg::DATA_W-1:0]      out_b,
  output logic [cpu_pkg::REG_ADDR_W-1:0]  out_rt,
  output logic                            out_slti_en
);

  import cpu_pkg::*;

  logic [REG_ADDR_W-1:0] rs;
  logic [IMM_W-1:0]      imm;
  operand_t              capture;
  operand_t              head;

  // r0 is hard-wired zero, so a writeback aimed at it must never reach operand A.
  always_comb begin
    rs              = in_instr[RS_MSB:RS_LSB];
    imm             = in_instr[IMM_W-1:0];
    capture.rt      = in_instr[RT_MSB:RT_LSB];
    capture.slti_en = (in_instr[OPC_MSB:OPC_LSB] == OPC_SLTI);
    capture.b       = extend_imm(imm, SIGN_EXT_IMM);
    if (rs == '0)
      capture.a = '0;
    else if (wb_we && (wb_addr == rs))
      capture.a = wb_data;
    else
      capture.a = in_rs_data;
  end

  operand_skid_buffer #(
    .W($bits(operand_t))
  ) u_buf (
    .clk_i       (clk),
    .rst_i       (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (capture),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head)
  );

  assign out_a       = head.a;
  assign out_b       = head.b;
  assign out_rt      = head.rt;
  assign out_slti_en = head.slti_en;

endmodule

// File: tb/tb_slti_operand_stage.sv
// Directed and randomized checks of the SLTI operand stage against a queue-based
// model; a second instance exercises zero-extension of the immediate.
module tb_slti_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid, inReady, outValid, outReady, wbWe, outSltiEn;
  logic [15:0] inInstr, inRsData, wbData, outA, outB;
  logic [2:0]  wbAddr, outRt;
  logic        zInReady, zOutValid, zOutSltiEn;
  logic [15:0] zOutA, zOutB;
  logic [2:0]  zOutRt;

  int checks = 0;
  int failures = 0;
  bit lastAccepted;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] bz;
    logic [2:0]  rt;
    logic        en;
  } expT;

  expT model[$];

  always #5 clk = ~clk;

  slti_operand_stage #(.SIGN_EXT_IMM(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .in_instr(inInstr), .in_rs_data(inRsData), .wb_we(wbWe), .wb_addr(wbAddr),
    .wb_data(wbData), .out_valid(outValid), .out_ready(outReady), .out_a(outA),
    .out_b(outB), .out_rt(outRt), .out_slti_en(outSltiEn)
  );

  slti_operand_stage #(.SIGN_EXT_IMM(1'b0)) dutZ (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(zInReady),
    .in_instr(inInstr), .in_rs_data(inRsData), .wb_we(wbWe), .wb_addr(wbAddr),
    .wb_data(wbData), .out_valid(zOutValid), .out_ready(outReady), .out_a(zOutA),
    .out_b(zOutB), .out_rt(zOutRt), .out_slti_en(zOutSltiEn)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: fields decoded with plain arithmetic on the instruction word.
  function automatic expT modelOperand(input logic [15:0] instr, input logic [15:0] rsData,
                                       input logic we, input logic [2:0] wa,
                                       input logic [15:0] wd);
    expT e;
    int  op, rs, rt, imm;
    op   = int'(instr) / 4096;
    rs   = (int'(instr) / 512) % 8;
    rt   = (int'(instr) / 64) % 8;
    imm  = int'(instr) % 64;
    e.a  = (rs == 0) ? 16'h0000 : ((we && int'(wa) == rs) ? wd : rsData);
    e.b  = 16'(imm >= 32 ? imm - 64 : imm);
    e.bz = 16'(imm);
    e.rt = 3'(rt);
    e.en = (op == 7);
    return e;
  endfunction

  task automatic scoreboardStep();
    bit expReady;
    expReady = (model.size() < 2);
    checkOutput("in_ready", 16'(inReady), 16'(expReady));
    checkOutput("z_in_ready", 16'(zInReady), 16'(expReady));
    checkOutput("out_valid", 16'(outValid), 16'(model.size() != 0));
    checkOutput("z_out_valid", 16'(zOutValid), 16'(model.size() != 0));
    if (model.size() != 0) begin
      checkOutput("head_a", outA, model[0].a);
      checkOutput("head_b", outB, model[0].b);
      checkOutput("head_rt", 16'(outRt), 16'(model[0].rt));
      checkOutput("head_en", 16'(outSltiEn), 16'(model[0].en));
      checkOutput("z_head_b", zOutB, model[0].bz);
      if (outReady) void'(model.pop_front());
    end
    lastAccepted = inValid && expReady;
    if (lastAccepted)
      model.push_back(modelOperand(inInstr, inRsData, wbWe, wbAddr, wbData));
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic [15:0] rsData,
                               input logic we, input logic [2:0] wa, input logic [15:0] wd,
                               input logic ordy);
    @(negedge clk);
    inValid  = v;
    inInstr  = instr;
    inRsData = rsData;
    wbWe     = we;
    wbAddr   = wa;
    wbData   = wd;
    outReady = ordy;
    #1;
    scoreboardStep();
  endtask

  task automatic drainAll();
    for (int i = 0; i < 8 && model.size() != 0; i++)
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          done;
    logic [15:0] rInstr;
    reset = 1'b1; inValid = 1'b0; inInstr = '0; inRsData = '0;
    wbWe = 1'b0; wbAddr = '0; wbData = '0; outReady = 1'b0;
    #1;
    checkOutput("rst_out_valid", 16'(outValid), 16'h0);
    checkOutput("rst_out_a", outA, 16'h0);
    checkOutput("rst_out_b", outB, 16'h0);
    checkOutput("rst_out_rt", 16'(outRt), 16'h0);
    checkOutput("rst_out_en", 16'(outSltiEn), 16'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    checkOutput("rst_in_ready", 16'(inReady), 16'h1);

    $display("[TB] basic SLTI");
    applyStimulus(1'b1, 16'h7245, 16'h0003, 1'b0, 3'd0, 16'h0, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    checkOutput("basic_valid", 16'(outValid), 16'h1);
    checkOutput("basic_a", outA, 16'h0003);
    checkOutput("basic_b", outB, 16'h0005);
    checkOutput("basic_rt", 16'(outRt), 16'h1);
    checkOutput("basic_en", 16'(outSltiEn), 16'h1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);

    $display("[TB] extension and forwarding");
    applyStimulus(1'b1, 16'h707F, 16'hAAAA, 1'b0, 3'd0, 16'h0, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    checkOutput("ext_signed", outB, 16'hFFFF);
    checkOutput("ext_zero", zOutB, 16'h003F);
    checkOutput("ext_rs0_a", outA, 16'h0000);
    applyStimulus(1'b1, 16'h74E0, 16'h0010, 1'b1, 3'd2, 16'h1234, 1'b1);
    applyStimulus(1'b1, 16'h3141, 16'h5555, 1'b1, 3'd0, 16'hFFFF, 1'b0);
    checkOutput("fwd_a", outA, 16'h1234);
    checkOutput("fwd_b_signed", outB, 16'hFFE0);
    checkOutput("fwd_b_zero", zOutB, 16'h0020);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    checkOutput("r0_wb_a", outA, 16'h0000);
    checkOutput("r0_wb_en", 16'(outSltiEn), 16'h0);
    checkOutput("r0_wb_rt", 16'(outRt), 16'h5);
    drainAll();

    $display("[TB] backpressure");
    applyStimulus(1'b1, 16'h7201, 16'h0101, 1'b0, 3'd0, 16'h0, 1'b0);
    applyStimulus(1'b1, 16'h7482, 16'h0202, 1'b0, 3'd0, 16'h0, 1'b0);
    applyStimulus(1'b1, 16'h76C3, 16'h0303, 1'b0, 3'd0, 16'h0, 1'b0);
    checkOutput("bp_full_ready", 16'(inReady), 16'h0);
    checkOutput("bp_head_a", outA, 16'h0101);
    repeat (2) applyStimulus(1'b1, 16'h76C3, 16'h0303, 1'b0, 3'd0, 16'h0, 1'b0);
    checkOutput("bp_stable_a", outA, 16'h0101);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      applyStimulus(1'b1, 16'h76C3, 16'h0303, 1'b0, 3'd0, 16'h0, 1'b1);
      done = lastAccepted;
    end
    checkOutput("bp_third_accepted", 16'(done), 16'h1);
    drainAll();

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 16'h7FFF, 16'h4444, 1'b0, 3'd0, 16'h0, 1'b0);
    applyStimulus(1'b1, 16'h7E3E, 16'h5555, 1'b0, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    inValid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 16'(outValid), 16'h0);
    checkOutput("mid_rst_a", outA, 16'h0);
    checkOutput("mid_rst_b", outB, 16'h0);
    checkOutput("mid_rst_rt", 16'(outRt), 16'h0);
    checkOutput("mid_rst_en", 16'(outSltiEn), 16'h0);
    model.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    checkOutput("mid_rst_ready", 16'(inReady), 16'h1);

    $display("[TB] random streaming");
    for (int i = 0; i < 120; i++) begin
      rInstr = 16'($urandom);
      applyStimulus(1'b1, rInstr, 16'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) != 0) ? rInstr[11:9] : 3'($urandom),
                    16'($urandom), ($urandom_range(0, 3) != 0));
    end
    drainAll();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
